// File: rtl/net_rx_merge.sv
// Receive-side merge for the inter-node link: one small FIFO per rx port,
// round-robin arbitration into a single registered output stream tagged with
// the source port, plus a free-running accepted-beat counter per port.
module net_rx_merge #(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned DATA_W     = 584,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SRC_W      = 2
) (
    input  logic                          io_ap_clk,
    input  logic                          io_ap_rst_n,
    input  logic                          io_net_init_flag,
    input  logic [NUM_PORTS-1:0]          io_rx_valid,
    output logic [NUM_PORTS-1:0]          io_rx_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]   io_rx_bits_data,
    output logic                          io_out_valid,
    input  logic                          io_out_ready,
    output logic [DATA_W-1:0]             io_out_bits_data,
    output logic [SRC_W-1:0]              io_out_src,
    output logic [NUM_PORTS*32-1:0]       io_rx_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_d [NUM_PORTS];
    logic [31:0]       rx_count_q [NUM_PORTS];
    logic [31:0]       rx_count_d [NUM_PORTS];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [SRC_W-1:0]  rr_q, rr_d;

    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic                 load;
    logic                 grant_valid;
    logic [SRC_W-1:0]     grant_idx;

    // Ready from registered occupancy and init flag only; never looks at valid.
    always_comb begin
        io_rx_ready = '0;
        push        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            io_rx_ready[i] = io_net_init_flag && (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]        = io_rx_valid[i] && io_rx_ready[i];
        end
    end

    // Round-robin grant: first non-empty FIFO at or above the rr pointer.
    always_comb begin
        int unsigned idx;
        load        = !out_valid_q || io_out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pop         = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(rr_q) + k) % NUM_PORTS;
            if (!grant_valid && (cnt_q[SRC_W'(idx)] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i] = load && grant_valid && (grant_idx == SRC_W'(i));
        end
    end

    // FIFO, counter and output-register next state.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rx_count_d  = rx_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_d        = rr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = io_rx_bits_data[i*DATA_W +: DATA_W];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
                rx_count_d[i]         = rx_count_q[i] + 32'd1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        if (load) begin
            if (grant_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[grant_idx][rd_ptr_q[grant_idx]];
                out_src_d   = grant_idx;
                rr_d        = (grant_idx == SRC_W'(NUM_PORTS - 1)) ? '0
                                                                 : grant_idx + SRC_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; async reset discards buffered and in-flight beats.
    always_ff @(posedge io_ap_clk or negedge io_ap_rst_n) begin
        if (!io_ap_rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                cnt_q[i]      <= '0;
                rx_count_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_q        <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rx_count_q  <= rx_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_q        <= rr_d;
        end
    end

    // Flatten per-port counters and drive registered outputs.
    always_comb begin
        io_rx_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            io_rx_count[i*32 +: 32] = rx_count_q[i];
        end
        io_out_valid     = out_valid_q;
        io_out_bits_data = out_data_q;
        io_out_src       = out_src_q;
    end

endmodule

// File: tb/tb_net_rx_merge.sv
// Directed bench for net_rx_merge: table-driven round-robin/stall vectors plus
// hand-written sequences for latency, backpressure, init drop and reset.
module tb_net_rx_merge;

    localparam int unsigned NP = 3;
    localparam int unsigned DW = 584;

    logic              clk;
    logic              rst_n;
    logic              init;
    logic [NP-1:0]     rx_valid;
    logic [NP-1:0]     rx_ready;
    logic [NP*DW-1:0]  rx_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic [NP*32-1:0]  rx_count;

    int checks;
    int failures;

    net_rx_merge #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .FIFO_DEPTH(4),
        .SRC_W     (2)
    ) dut (
        .io_ap_clk       (clk),
        .io_ap_rst_n     (rst_n),
        .io_net_init_flag(init),
        .io_rx_valid     (rx_valid),
        .io_rx_ready     (rx_ready),
        .io_rx_bits_data (rx_data),
        .io_out_valid    (out_valid),
        .io_out_ready    (out_ready),
        .io_out_bits_data(out_data),
        .io_out_src      (out_src),
        .io_rx_count     (rx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          init;
        logic [NP-1:0] valid;
        logic          oready;
        logic [NP-1:0] exp_ready;
        logic          exp_valid;
        logic [1:0]    exp_src;
        logic [15:0]   exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_of(input int p);
        return rx_count[p*32 +: 32];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        init      = 1'b0;
        rx_valid  = '0;
        out_ready = 1'b0;
        rx_data   = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[12];
    int   n_drv[NP];

    initial begin
        logic [NP-1:0] hs;
        checks   = 0;
        failures = 0;

        // Round-robin streaming with all ports valid, then a two-cycle stall.
        vecs[0]  = '{1'b1, 3'b111, 1'b1, 3'b111, 1'b0, 2'd0, 16'h000};
        vecs[1]  = '{1'b1, 3'b111, 1'b1, 3'b111, 1'b1, 2'd0, 16'h000};
        vecs[2]  = '{1'b1, 3'b111, 1'b1, 3'b111, 1'b1, 2'd1, 16'h100};
        vecs[3]  = '{1'b1, 3'b111, 1'b1, 3'b111, 1'b1, 2'd2, 16'h200};
        vecs[4]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 16'h001};
        vecs[5]  = '{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 16'h101};
        vecs[6]  = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 16'h201};
        vecs[7]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 16'h002};
        vecs[8]  = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 16'h002};
        vecs[9]  = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 16'h002};
        vecs[10] = '{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 16'h102};
        vecs[11] = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 16'h202};

        // Reset state.
        do_reset();
        chk("reset_ready", DW'(rx_ready), DW'(3'b000));
        chk("reset_out_valid", DW'(out_valid), DW'(1'b0));
        chk("reset_out_data", out_data, '0);
        chk("reset_out_src", DW'(out_src), DW'(2'd0));
        chk("reset_counts", DW'(rx_count), '0);

        // Single beat from port 1: visible after the second edge.
        init     = 1'b1;
        rx_valid = 3'b010;
        rx_data[1*DW +: DW] = DW'(16'hABC);
        #1;
        chk("t1_ready", DW'(rx_ready), DW'(3'b111));
        tick();
        rx_valid = '0;
        chk("t1_valid_e1", DW'(out_valid), DW'(1'b0));
        chk("t1_count1", DW'(cnt_of(1)), DW'(32'd1));
        tick();
        chk("t1_valid_e2", DW'(out_valid), DW'(1'b1));
        chk("t1_data", out_data, DW'(16'hABC));
        chk("t1_src", DW'(out_src), DW'(2'd1));
        out_ready = 1'b1;
        tick();
        chk("t1_drained", DW'(out_valid), DW'(1'b0));

        // Init low: port 2 valid is never accepted.
        init     = 1'b0;
        rx_valid = 3'b100;
        #1;
        chk("t4_ready", DW'(rx_ready), DW'(3'b000));
        tick();
        tick();
        tick();
        chk("t4_count2", DW'(cnt_of(2)), DW'(32'd0));
        chk("t4_count1_hold", DW'(cnt_of(1)), DW'(32'd1));
        chk("t4_no_out", DW'(out_valid), DW'(1'b0));

        // Table: round-robin merge and stall from a fresh reset.
        do_reset();
        for (int p = 0; p < NP; p++) n_drv[p] = 0;
        for (int k = 0; k < 12; k++) begin
            init      = vecs[k].init;
            rx_valid  = vecs[k].valid;
            out_ready = vecs[k].oready;
            for (int p = 0; p < NP; p++) begin
                rx_data[p*DW +: DW] = DW'(p * 'h100 + n_drv[p]);
            end
            #1;
            hs = rx_valid & rx_ready;
            tick();
            for (int p = 0; p < NP; p++) if (hs[p]) n_drv[p]++;
            chk($sformatf("rr%0d_ready", k), DW'(rx_ready), DW'(vecs[k].exp_ready));
            chk($sformatf("rr%0d_valid", k), DW'(out_valid), DW'(vecs[k].exp_valid));
            if (vecs[k].exp_valid) begin
                chk($sformatf("rr%0d_src", k), DW'(out_src), DW'(vecs[k].exp_src));
                chk($sformatf("rr%0d_data", k), out_data, DW'(vecs[k].exp_data));
            end
        end
        chk("rr_count0", DW'(cnt_of(0)), DW'(32'd7));
        chk("rr_count1", DW'(cnt_of(1)), DW'(32'd7));
        chk("rr_count2", DW'(cnt_of(2)), DW'(32'd6));

        // Backpressure on port 0: 1 in out reg + 4 buffered, then init drop.
        do_reset();
        init      = 1'b1;
        out_ready = 1'b0;
        rx_valid  = 3'b001;
        for (int b = 1; b <= 5; b++) begin
            rx_data[0 +: DW] = DW'(32'h30 + b);
            tick();
        end
        rx_data[0 +: DW] = DW'(32'h36);
        chk("t3_full_ready", DW'(rx_ready), DW'(3'b110));
        chk("t3_count5", DW'(cnt_of(0)), DW'(32'd5));
        tick();
        chk("t3_no_push_full", DW'(cnt_of(0)), DW'(32'd5));
        chk("t3_hold_data", out_data, DW'(32'h31));
        rx_valid = '0;
        init     = 1'b0;
        #1;
        chk("t3_init_drop", DW'(rx_ready), DW'(3'b000));
        out_ready = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            chk($sformatf("t3_drain%0d_valid", b), DW'(out_valid), DW'(1'b1));
            chk($sformatf("t3_drain%0d_data", b), out_data, DW'(32'h30 + b));
            tick();
        end
        chk("t3_drain_end", DW'(out_valid), DW'(1'b0));
        chk("t3_count_hold", DW'(cnt_of(0)), DW'(32'd5));

        // Async reset with beats buffered.
        init      = 1'b1;
        out_ready = 1'b0;
        rx_valid  = 3'b111;
        for (int p = 0; p < NP; p++) rx_data[p*DW +: DW] = DW'(32'h50 + p);
        tick();
        rx_valid = '0;
        tick();
        chk("t6_pre_valid", DW'(out_valid), DW'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", DW'(out_valid), DW'(1'b0));
        chk("t6_async_counts", DW'(rx_count), '0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t6_ready_after", DW'(rx_ready), DW'(3'b111));
        tick();
        tick();
        tick();
        chk("t6_fifos_empty", DW'(out_valid), DW'(1'b0));
        chk("t6_counts_zero", DW'(rx_count), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
